// File: rtl/uart_sys_pkg.sv
// rtl/uart_sys_pkg.sv - shared opcodes, operand addresses and receiver FSM states
package uart_sys_pkg;

   localparam logic [7:0] CMD_REG_WRITE = 8'hAA;
   localparam logic [7:0] CMD_REG_READ  = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP    = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP   = 8'hDD;

   localparam int OPERAND_A_ADDR = 0;
   localparam int OPERAND_B_ADDR = 1;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      ALU_OPA,
      ALU_OPB,
      ALU_FUNC
   } rx_state_t;

endpackage

// File: rtl/frame_timeout_counter.sv
// rtl/frame_timeout_counter.sv - inter-byte idle counter that flags an abandoned frame
module frame_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (count_en)
         count <= count + 1'b1;
   end

   assign expired = count_en && (count == LAST);

endmodule

// File: rtl/uart_receiver_controller.sv
// rtl/uart_receiver_controller.sv - parses received UART bytes into reg-file and ALU strobes
module uart_receiver_controller
   import uart_sys_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int ALU_FUNC_WIDTH = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      uart_receiver_controller_en,
   input  logic                      receiver_parallel_data_valid,
   input  logic [DATA_WIDTH-1:0]     receiver_parallel_data,
   output logic                      reg_file_write_en,
   output logic                      reg_file_read_en,
   output logic [ADDR_WIDTH-1:0]     reg_file_address,
   output logic [DATA_WIDTH-1:0]     reg_file_write_data,
   output logic                      alu_en,
   output logic [ALU_FUNC_WIDTH-1:0] alu_function,
   output logic                      frame_error
);

   rx_state_t                 state, state_nxt;
   logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_nxt;
   logic                      wr_nxt, rd_nxt, alu_nxt, err_nxt;
   logic [ADDR_WIDTH-1:0]     addr_nxt;
   logic [DATA_WIDTH-1:0]     data_nxt;
   logic [ALU_FUNC_WIDTH-1:0] func_nxt;
   logic                      accept, in_frame, count_en, expired;

   assign accept   = uart_receiver_controller_en && receiver_parallel_data_valid;
   assign in_frame = (state != IDLE);
   assign count_en = uart_receiver_controller_en && in_frame;

   frame_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept || !in_frame || expired),
      .count_en (count_en),
      .expired  (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= IDLE;
         wr_addr_q           <= '0;
         reg_file_write_en   <= 1'b0;
         reg_file_read_en    <= 1'b0;
         reg_file_address    <= '0;
         reg_file_write_data <= '0;
         alu_en              <= 1'b0;
         alu_function        <= '0;
         frame_error         <= 1'b0;
      end else begin
         state               <= state_nxt;
         wr_addr_q           <= wr_addr_nxt;
         reg_file_write_en   <= wr_nxt;
         reg_file_read_en    <= rd_nxt;
         reg_file_address    <= addr_nxt;
         reg_file_write_data <= data_nxt;
         alu_en              <= alu_nxt;
         alu_function        <= func_nxt;
         frame_error         <= err_nxt;
      end
   end

   // An accepted byte takes priority over a timeout landing in the same cycle.
   always_comb begin
      state_nxt   = state;
      wr_addr_nxt = wr_addr_q;
      wr_nxt      = 1'b0;
      rd_nxt      = 1'b0;
      alu_nxt     = 1'b0;
      err_nxt     = 1'b0;
      addr_nxt    = reg_file_address;
      data_nxt    = reg_file_write_data;
      func_nxt    = alu_function;
      if (accept) begin
         case (state)
            IDLE: begin
               case (receiver_parallel_data)
                  CMD_REG_WRITE: state_nxt = WR_ADDR;
                  CMD_REG_READ:  state_nxt = RD_ADDR;
                  CMD_ALU_OP:    state_nxt = ALU_OPA;
                  CMD_ALU_NOP:   state_nxt = ALU_FUNC;
                  default:       err_nxt   = 1'b1;
               endcase
            end
            WR_ADDR: begin
               wr_addr_nxt = receiver_parallel_data[ADDR_WIDTH-1:0];
               state_nxt   = WR_DATA;
            end
            WR_DATA: begin
               wr_nxt    = 1'b1;
               addr_nxt  = wr_addr_q;
               data_nxt  = receiver_parallel_data;
               state_nxt = IDLE;
            end
            RD_ADDR: begin
               rd_nxt    = 1'b1;
               addr_nxt  = receiver_parallel_data[ADDR_WIDTH-1:0];
               state_nxt = IDLE;
            end
            ALU_OPA: begin
               wr_nxt    = 1'b1;
               addr_nxt  = ADDR_WIDTH'(OPERAND_A_ADDR);
               data_nxt  = receiver_parallel_data;
               state_nxt = ALU_OPB;
            end
            ALU_OPB: begin
               wr_nxt    = 1'b1;
               addr_nxt  = ADDR_WIDTH'(OPERAND_B_ADDR);
               data_nxt  = receiver_parallel_data;
               state_nxt = ALU_FUNC;
            end
            ALU_FUNC: begin
               alu_nxt   = 1'b1;
               func_nxt  = receiver_parallel_data[ALU_FUNC_WIDTH-1:0];
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end else if (expired) begin
         err_nxt   = 1'b1;
         state_nxt = IDLE;
      end
   end

endmodule

// File: tb/tb_uart_receiver_controller.sv
// tb/tb_uart_receiver_controller.sv - directed and randomized bench against a frame-level model
module tb_uart_receiver_controller;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int FW = 4;
   localparam int T  = 1000;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic          valid;
   logic [DW-1:0] data;
   logic          wr_en, rd_en, alu_en;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [FW-1:0] func;
   logic          ferr;

   always #5 clk = ~clk;

   uart_receiver_controller #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .ALU_FUNC_WIDTH (FW),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk                          (clk),
      .reset                        (reset),
      .uart_receiver_controller_en  (en),
      .receiver_parallel_data_valid (valid),
      .receiver_parallel_data       (data),
      .reg_file_write_en            (wr_en),
      .reg_file_read_en             (rd_en),
      .reg_file_address             (addr),
      .reg_file_write_data          (wdata),
      .alu_en                       (alu_en),
      .alu_function                 (func),
      .frame_error                  (ferr)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: bytes of the frame in progress plus idle cycles since the last byte.
   logic [7:0]    frame[$];
   int            idle_cnt;
   logic          m_wr, m_rd, m_alu, m_err;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic [FW-1:0] m_func;

   function automatic bit is_opcode(input logic [7:0] b);
      return (b == 8'hAA) || (b == 8'hBB) || (b == 8'hCC) || (b == 8'hDD);
   endfunction

   task automatic model_reset();
      frame.delete();
      idle_cnt = 0;
      m_wr = 0; m_rd = 0; m_alu = 0; m_err = 0;
      m_addr = '0; m_data = '0; m_func = '0;
   endtask

   task automatic model_step(input logic e, input logic v, input logic [7:0] b);
      m_wr = 0; m_rd = 0; m_alu = 0; m_err = 0;
      if (e && v) begin
         idle_cnt = 0;
         if (frame.size() == 0) begin
            if (is_opcode(b)) frame.push_back(b);
            else m_err = 1;
         end else begin
            frame.push_back(b);
            case (frame[0])
               8'hAA: if (frame.size() == 3) begin
                  m_wr = 1; m_addr = AW'(frame[1] % 16); m_data = frame[2]; frame.delete();
               end
               8'hBB: begin
                  m_rd = 1; m_addr = AW'(frame[1] % 16); frame.delete();
               end
               8'hCC: begin
                  if (frame.size() == 2) begin m_wr = 1; m_addr = 0; m_data = frame[1]; end
                  else if (frame.size() == 3) begin m_wr = 1; m_addr = 1; m_data = frame[2]; end
                  else begin m_alu = 1; m_func = FW'(frame[3] % 16); frame.delete(); end
               end
               8'hDD: begin
                  m_alu = 1; m_func = FW'(frame[1] % 16); frame.delete();
               end
               default: frame.delete();
            endcase
         end
      end else if (e && frame.size() != 0) begin
         idle_cnt++;
         if (idle_cnt == T) begin
            m_err = 1;
            frame.delete();
            idle_cnt = 0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "/write_en"}, 32'(wr_en), 32'(m_wr));
      check({tag, "/read_en"}, 32'(rd_en), 32'(m_rd));
      check({tag, "/alu_en"}, 32'(alu_en), 32'(m_alu));
      check({tag, "/frame_error"}, 32'(ferr), 32'(m_err));
      check({tag, "/address"}, 32'(addr), 32'(m_addr));
      check({tag, "/write_data"}, 32'(wdata), 32'(m_data));
      check({tag, "/alu_function"}, 32'(func), 32'(m_func));
      check({tag, "/one_strobe"}, 32'(int'(wr_en) + int'(rd_en) + int'(alu_en) <= 1), 32'd1);
   endtask

   task automatic cyc(input logic e, input logic v, input logic [7:0] b, input string tag);
      en = e; valid = v; data = b;
      model_step(e, v, b);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic send(input logic [7:0] b, input string tag);
      cyc(1'b1, 1'b1, b, tag);
   endtask

   task automatic idle(input int n, input logic e, input string tag);
      for (int i = 0; i < n; i++)
         cyc(e, ~e & 1'($urandom), 8'($urandom), tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1; valid = 1'b0; en = 1'b1; data = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      check_all(tag);
   endtask

   task automatic random_frame();
      int kind;
      int len;
      logic [7:0] op;
      kind = $urandom_range(0, 4);
      case (kind)
         0: begin op = 8'hAA; len = 3; end
         1: begin op = 8'hBB; len = 2; end
         2: begin op = 8'hCC; len = 4; end
         3: begin op = 8'hDD; len = 2; end
         default: begin
            op = 8'($urandom);
            while (is_opcode(op)) op = 8'($urandom);
            len = 1;
         end
      endcase
      for (int i = 0; i < len; i++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++)
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), "rand_gap");
         send((i == 0) ? op : 8'($urandom), "rand_byte");
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; valid = 1'b0; data = '0;
      model_reset();
      do_reset("reset");

      send(8'hAA, "wr_op"); send(8'h05, "wr_addr"); send(8'h3C, "wr_data");
      idle(2, 1'b1, "wr_after");

      send(8'hBB, "rd_op"); send(8'h07, "rd_addr");
      idle(1, 1'b1, "rd_after");

      send(8'hCC, "alu_op"); send(8'h12, "alu_opa"); send(8'h34, "alu_opb"); send(8'h02, "alu_func");
      idle(1, 1'b1, "alu_after");

      send(8'hDD, "nop_op"); send(8'hFF, "nop_func_upper");
      send(8'h55, "bad_op");
      send(8'hBB, "rd2_op"); send(8'hF3, "rd2_addr_upper");

      send(8'hAA, "to_op"); send(8'h05, "to_addr");
      idle(T, 1'b1, "to_idle");
      send(8'h3C, "to_late_byte");

      send(8'hAA, "edge_op"); send(8'h09, "edge_addr");
      idle(T - 1, 1'b1, "edge_idle");
      send(8'h77, "edge_data_same_cycle");
      idle(2, 1'b1, "edge_after");

      cyc(1'b0, 1'b1, 8'hAA, "dis_ignored");
      idle(2, 1'b1, "dis_after");

      send(8'hAA, "frz_op");
      idle(2000, 1'b0, "frz_hold");
      send(8'h05, "frz_addr"); send(8'h3C, "frz_data");

      send(8'hCC, "rst_op"); send(8'h11, "rst_opa");
      do_reset("rst_mid");
      send(8'h3C, "rst_after_byte");

      for (int n = 0; n < 400; n++)
         random_frame();
      idle(4, 1'b1, "final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
